// File: rtl/ddr3_partial_rd_capture.sv
// ddr3_partial_rd_capture: assembles DFI read beats into 128-bit burst words,
// applies partial-read truncation and flags dnv, unexpected and overrun beats.
module ddr3_partial_rd_capture #(
  parameter int DDR_BURST_LEN   = 4,
  parameter int DDR_DATA_W      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 rd_issue_i,
  input  logic [DDR_DATA_W-1:0]                dfi_rddata_i,
  input  logic                                 dfi_rddata_valid_i,
  input  logic [1:0]                           dfi_rddata_dnv_i,
  input  logic                                 partial_read_en_i,
  input  logic [2:0]                           partial_read_cycles_i,
  input  logic                                 rd_ready_i,
  output logic [DDR_BURST_LEN*DDR_DATA_W-1:0]  rddata_o,
  output logic [DDR_BURST_LEN-1:0]             rddata_beat_mask_o,
  output logic                                 rddata_valid_o,
  output logic                                 busy_o,
  output logic                                 rd_timeout_o,
  output logic [3:0]                           err_flags_o
);

  localparam int WORD_W  = DDR_BURST_LEN * DDR_DATA_W;
  localparam int CNT_W   = $clog2(DDR_BURST_LEN);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

  state_t                  state_reg;
  logic [2:0]              outstanding_reg;
  logic [CNT_W-1:0]        beat_cnt_reg;
  logic [2:0]              keep_reg;
  logic [TIMER_W-1:0]      timer_reg;
  logic [WORD_W-1:0]       coll_data_reg;
  logic [DDR_BURST_LEN-1:0] coll_mask_reg;
  logic [WORD_W-1:0]       out_data_reg;
  logic [DDR_BURST_LEN-1:0] out_mask_reg;
  logic                    out_valid_reg;
  logic                    rd_timeout_reg;
  logic [3:0]              err_reg;

  logic                    in_collect;
  logic                    accept_beat;
  logic                    timer_run;
  logic                    timeout_fire;
  logic                    burst_done;
  logic                    out_free;
  logic                    beat_keep;
  logic [2:0]              keep_snap;
  logic [2:0]              keep_eff;
  logic [CNT_W-1:0]        slot_sel;
  logic [WORD_W-1:0]       base_data;
  logic [DDR_BURST_LEN-1:0] base_mask;
  logic [WORD_W-1:0]       merge_data;
  logic [DDR_BURST_LEN-1:0] merge_mask;
  logic [WORD_W-1:0]       done_data;
  logic [DDR_BURST_LEN-1:0] done_mask;

  assign in_collect  = (state_reg == S_COLLECT);
  assign accept_beat = dfi_rddata_valid_i &&
                       (in_collect || (state_reg == S_IDLE && outstanding_reg != 3'd0));
  assign timer_run   = (outstanding_reg != 3'd0) && (state_reg != S_HOLD);
  assign timeout_fire = timer_run && !dfi_rddata_valid_i && !rd_issue_i &&
                        (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign burst_done  = (accept_beat && in_collect && beat_cnt_reg == CNT_W'(DDR_BURST_LEN - 1)) ||
                       timeout_fire;
  assign out_free    = !out_valid_reg || rd_ready_i;

  // Keep count is latched on the first beat so a mid-burst config change is ignored.
  assign keep_snap = (partial_read_en_i && partial_read_cycles_i != 3'd0 &&
                      partial_read_cycles_i < 3'(DDR_BURST_LEN))
                     ? partial_read_cycles_i : 3'(DDR_BURST_LEN);
  assign keep_eff  = in_collect ? keep_reg : keep_snap;
  assign slot_sel  = in_collect ? beat_cnt_reg : '0;
  assign base_data = in_collect ? coll_data_reg : '0;
  assign base_mask = in_collect ? coll_mask_reg : '0;
  assign beat_keep = dfi_rddata_valid_i && (dfi_rddata_dnv_i == 2'b00) &&
                     (3'(slot_sel) < keep_eff);

  for (genvar gi = 0; gi < DDR_BURST_LEN; gi++) begin : g_slot
    assign merge_data[gi*DDR_DATA_W +: DDR_DATA_W] =
      (slot_sel == CNT_W'(gi)) ? (beat_keep ? dfi_rddata_i : '0)
                               : base_data[gi*DDR_DATA_W +: DDR_DATA_W];
    assign merge_mask[gi] = (slot_sel == CNT_W'(gi)) ? beat_keep : base_mask[gi];
  end

  // A timeout completes whatever has been collected; unfilled slots stay zero.
  assign done_data = timeout_fire ? base_data : merge_data;
  assign done_mask = timeout_fire ? base_mask : merge_mask;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= S_IDLE;
      outstanding_reg <= 3'd0;
      beat_cnt_reg    <= '0;
      keep_reg        <= 3'(DDR_BURST_LEN);
      timer_reg       <= '0;
      coll_data_reg   <= '0;
      coll_mask_reg   <= '0;
      out_data_reg    <= '0;
      out_mask_reg    <= '0;
      out_valid_reg   <= 1'b0;
      rd_timeout_reg  <= 1'b0;
      err_reg         <= 4'd0;
    end else begin
      rd_timeout_reg <= timeout_fire;

      if (rd_issue_i && !burst_done) begin
        if (outstanding_reg == 3'(MAX_OUTSTANDING))
          err_reg[2] <= 1'b1;
        else
          outstanding_reg <= outstanding_reg + 3'd1;
      end else if (burst_done && !rd_issue_i) begin
        outstanding_reg <= outstanding_reg - 3'd1;
      end

      if (!timer_run || dfi_rddata_valid_i || rd_issue_i || timeout_fire)
        timer_reg <= '0;
      else
        timer_reg <= timer_reg + TIMER_W'(1);

      if (dfi_rddata_valid_i) begin
        if (state_reg == S_HOLD)
          err_reg[3] <= 1'b1;
        else if (!accept_beat)
          err_reg[1] <= 1'b1;
        else if (dfi_rddata_dnv_i != 2'b00)
          err_reg[0] <= 1'b1;
      end

      if (out_valid_reg && rd_ready_i)
        out_valid_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (accept_beat) begin
            coll_data_reg <= merge_data;
            coll_mask_reg <= merge_mask;
            keep_reg      <= keep_snap;
            beat_cnt_reg  <= CNT_W'(1);
            state_reg     <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (accept_beat) begin
            coll_data_reg <= merge_data;
            coll_mask_reg <= merge_mask;
            beat_cnt_reg  <= beat_cnt_reg + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (rd_ready_i) begin
            out_data_reg  <= coll_data_reg;
            out_mask_reg  <= coll_mask_reg;
            out_valid_reg <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase

      // Completion overrides the per-state updates above.
      if (burst_done) begin
        beat_cnt_reg <= '0;
        if (out_free) begin
          out_data_reg  <= done_data;
          out_mask_reg  <= done_mask;
          out_valid_reg <= 1'b1;
          state_reg     <= S_IDLE;
        end else begin
          coll_data_reg <= done_data;
          coll_mask_reg <= done_mask;
          state_reg     <= S_HOLD;
        end
      end
    end
  end

  assign rddata_o           = out_data_reg;
  assign rddata_beat_mask_o = out_mask_reg;
  assign rddata_valid_o     = out_valid_reg;
  assign busy_o             = (outstanding_reg != 3'd0) || in_collect;
  assign rd_timeout_o       = rd_timeout_reg;
  assign err_flags_o        = err_reg;

endmodule

// File: tb/tb_ddr3_partial_rd_capture.sv
// Directed bench for ddr3_partial_rd_capture: a queue-based reference model is
// checked every cycle, plus literal expectations for each scenario.
module tb_ddr3_partial_rd_capture;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         rd_issue_i = 1'b0;
  logic [31:0]  dfi_rddata_i = '0;
  logic         dfi_rddata_valid_i = 1'b0;
  logic [1:0]   dfi_rddata_dnv_i = '0;
  logic         partial_read_en_i = 1'b0;
  logic [2:0]   partial_read_cycles_i = '0;
  logic         rd_ready_i = 1'b1;
  logic [127:0] rddata_o;
  logic [3:0]   rddata_beat_mask_o;
  logic         rddata_valid_o;
  logic         busy_o;
  logic         rd_timeout_o;
  logic [3:0]   err_flags_o;

  ddr3_partial_rd_capture dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .rd_issue_i            (rd_issue_i),
    .dfi_rddata_i          (dfi_rddata_i),
    .dfi_rddata_valid_i    (dfi_rddata_valid_i),
    .dfi_rddata_dnv_i      (dfi_rddata_dnv_i),
    .partial_read_en_i     (partial_read_en_i),
    .partial_read_cycles_i (partial_read_cycles_i),
    .rd_ready_i            (rd_ready_i),
    .rddata_o              (rddata_o),
    .rddata_beat_mask_o    (rddata_beat_mask_o),
    .rddata_valid_o        (rddata_valid_o),
    .busy_o                (busy_o),
    .rd_timeout_o          (rd_timeout_o),
    .err_flags_o           (err_flags_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  bit live = 1'b0;

  // Reference model: reads in flight, beats of the burst being gathered,
  // and a queue of finished words (front = word presented to the host).
  int           m_out = 0;
  int           m_nbeats = 0;
  int           m_keep = 4;
  int           m_idle = 0;
  logic [31:0]  m_bd[4];
  logic [1:0]   m_bdnv[4];
  logic [127:0] q_data[$];
  logic [3:0]   q_mask[$];
  logic [3:0]   m_err = '0;
  logic         m_to = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit done = 1'b0;
    bit fire = 1'b0;
    bit hold;
    bit running;
    logic [127:0] w;
    logic [3:0]   wm;
    if (rst_i) begin
      m_out = 0; m_nbeats = 0; m_keep = 4; m_idle = 0;
      q_data.delete(); q_mask.delete();
      m_err = '0; m_to = 1'b0;
      return;
    end
    hold    = (q_data.size() == 2);
    running = (m_out > 0) && !hold;
    if (dfi_rddata_valid_i) begin
      if (hold) m_err[3] = 1'b1;
      else if (m_nbeats == 0 && m_out == 0) m_err[1] = 1'b1;
      else begin
        if (m_nbeats == 0)
          m_keep = (partial_read_en_i && partial_read_cycles_i >= 3'd1 && partial_read_cycles_i <= 3'd3)
                   ? int'(partial_read_cycles_i) : 4;
        if (dfi_rddata_dnv_i != 2'b00) m_err[0] = 1'b1;
        m_bd[m_nbeats]   = dfi_rddata_i;
        m_bdnv[m_nbeats] = dfi_rddata_dnv_i;
        m_nbeats++;
        done = (m_nbeats == 4);
      end
    end
    if (dfi_rddata_valid_i || rd_issue_i || !running) m_idle = 0;
    else begin
      m_idle++;
      if (m_idle == 64) begin
        fire = 1'b1; done = 1'b1; m_idle = 0;
      end
    end
    m_to = fire;
    if (rd_issue_i && !done) begin
      if (m_out == 4) m_err[2] = 1'b1;
      else m_out++;
    end else if (done && !rd_issue_i) begin
      m_out--;
    end
    if (rd_ready_i && q_data.size() > 0) begin
      void'(q_data.pop_front());
      void'(q_mask.pop_front());
    end
    if (done) begin
      w = '0; wm = '0;
      for (int i = 0; i < m_nbeats; i++)
        if (i < m_keep && m_bdnv[i] == 2'b00) begin
          w[i*32 +: 32] = m_bd[i];
          wm[i] = 1'b1;
        end
      q_data.push_back(w);
      q_mask.push_back(wm);
      m_nbeats = 0;
    end
  endtask

  // Compare against the model on the falling edge, then advance the model with
  // the inputs the DUT will sample on the next rising edge.
  initial forever begin
    @(negedge clk_i);
    if (live) begin
      chk("valid", rddata_valid_o, q_data.size() > 0);
      if (q_data.size() > 0) begin
        chk("data", rddata_o, q_data[0]);
        chk("mask", rddata_beat_mask_o, q_mask[0]);
      end
      chk("busy", busy_o, (m_out != 0) || (m_nbeats > 0));
      chk("timeout", rd_timeout_o, m_to);
      chk("err", err_flags_o, m_err);
      if (rddata_valid_o && rd_ready_i)
        $display("xfer data=%h mask=%b err=%b", rddata_o, rddata_beat_mask_o, err_flags_o);
    end
    model_step();
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue();
    rd_issue_i = 1'b1;
    tick();
    rd_issue_i = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] dnv);
    dfi_rddata_valid_i = 1'b1;
    dfi_rddata_i = d;
    dfi_rddata_dnv_i = dnv;
    tick();
    dfi_rddata_valid_i = 1'b0;
    dfi_rddata_dnv_i = 2'b00;
  endtask

  task automatic burst(input logic [31:0] base);
    for (int i = 0; i < 4; i++) beat(base * 32'(i + 1), 2'b00);
  endtask

  task automatic reset_pulse();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst_i = 1'b0;
    live = 1'b1;
    chk("reset valid", rddata_valid_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset err", err_flags_o, 0);

    // 1: full burst, latency one cycle after the last beat
    issue();
    burst(32'h11111111);
    chk("t1 valid", rddata_valid_o, 1);
    chk("t1 data", rddata_o, 128'h44444444_33333333_22222222_11111111);
    chk("t1 mask", rddata_beat_mask_o, 4'hF);
    chk("t1 busy", busy_o, 0);
    tick();
    chk("t1 drained", rddata_valid_o, 0);

    // 2: truncation to two beats, then cycles=0 means full burst
    partial_read_en_i = 1'b1;
    partial_read_cycles_i = 3'd2;
    issue();
    burst(32'h11111111);
    chk("t2 data", rddata_o, 128'h00000000_00000000_22222222_11111111);
    chk("t2 mask", rddata_beat_mask_o, 4'b0011);
    partial_read_cycles_i = 3'd0;
    issue();
    burst(32'h11111111);
    chk("t2 full mask", rddata_beat_mask_o, 4'hF);
    partial_read_en_i = 1'b0;

    // 3: dnv on beat 2
    issue();
    beat(32'h11111111, 2'b00);
    beat(32'h22222222, 2'b00);
    beat(32'h33333333, 2'b01);
    beat(32'h44444444, 2'b00);
    chk("t3 data", rddata_o, 128'h44444444_00000000_22222222_11111111);
    chk("t3 mask", rddata_beat_mask_o, 4'b1011);
    chk("t3 err0", err_flags_o[0], 1);

    // 4: timeout after two beats, then an unexpected beat
    issue();
    beat(32'h11111111, 2'b00);
    beat(32'h22222222, 2'b00);
    repeat (63) tick();
    chk("t4 no early timeout", rd_timeout_o, 0);
    tick();
    chk("t4 timeout", rd_timeout_o, 1);
    chk("t4 mask", rddata_beat_mask_o, 4'b0011);
    chk("t4 data", rddata_o, 128'h00000000_00000000_22222222_11111111);
    chk("t4 busy", busy_o, 0);
    tick();
    beat(32'hDEADBEEF, 2'b00);
    chk("t4 err1", err_flags_o[1], 1);

    // 5: back-to-back bursts with the host stalled
    rd_ready_i = 1'b0;
    issue();
    issue();
    burst(32'h0A0A0A0A);
    burst(32'h0B0B0B0B);
    chk("t5 first held", rddata_o, 128'h28282828_1E1E1E1E_14141414_0A0A0A0A);
    issue();
    burst(32'h0C0C0C0C);
    chk("t5 err3", err_flags_o[3], 1);
    chk("t5 still first", rddata_o, 128'h28282828_1E1E1E1E_14141414_0A0A0A0A);
    rd_ready_i = 1'b1;
    tick();
    chk("t5 second", rddata_o, 128'h2C2C2C2C_21212121_16161616_0B0B0B0B);
    chk("t5 second valid", rddata_valid_o, 1);
    tick();
    chk("t5 drained", rddata_valid_o, 0);

    // 6: issue overflow, reset mid-burst, clean recovery
    reset_pulse();
    repeat (5) issue();
    chk("t6 err2", err_flags_o[2], 1);
    chk("t6 busy", busy_o, 1);
    beat(32'h55555555, 2'b00);
    beat(32'h66666666, 2'b00);
    reset_pulse();
    chk("t6 rst valid", rddata_valid_o, 0);
    chk("t6 rst data", rddata_o, 0);
    chk("t6 rst busy", busy_o, 0);
    chk("t6 rst err", err_flags_o, 0);
    issue();
    burst(32'h01010101);
    chk("t6 clean data", rddata_o, 128'h04040404_03030303_02020202_01010101);
    chk("t6 clean mask", rddata_beat_mask_o, 4'hF);
    chk("t6 clean err", err_flags_o, 0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
